// File: rtl/if_fetch_ctrl.sv
// Fetch-stage sequencer: owns the fetch PC, issues one instruction SRAM request
// at a time over req/addr_ok/data_ok, buffers the returned word for ID, and
// applies branch redirects while discarding fetches made stale by them.
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        id_allowin,

    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,

    output logic        fs_to_ds_valid,
    output logic [31:0] fs_pc,
    output logic [31:0] fs_inst
);

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned INST_W  = 32;
    localparam int unsigned PC_STEP = 4;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [ADDR_W-1:0]   pc;
    logic [ADDR_W-1:0]   pc_nxt;
    logic [ADDR_W-1:0]   redir_tgt;
    logic [ADDR_W-1:0]   redir_tgt_nxt;
    logic                redirect_pend;
    logic                redirect_pend_nxt;
    logic                cancel;
    logic                cancel_nxt;
    logic                load_buf;

    logic                handshake;
    logic                hold_valid;

    // The buffered instruction is offered only in HOLD and is squashed by a
    // redirect arriving in the same cycle.
    assign hold_valid     = (state == S_HOLD) && !br_taken && !reset;
    assign fs_to_ds_valid = hold_valid;
    assign handshake      = hold_valid && id_allowin;

    // Request is a pure state decode; the address is the PC, which is only
    // allowed to move outside REQ so it stays stable until acceptance.
    assign inst_req  = (state == S_REQ) && !reset;
    assign inst_addr = pc;

    // State register and fetch bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_REQ;
            pc            <= RESET_PC;
            redir_tgt     <= ADDR_W'(0);
            redirect_pend <= 1'b0;
            cancel        <= 1'b0;
        end else begin
            state         <= state_nxt;
            pc            <= pc_nxt;
            redir_tgt     <= redir_tgt_nxt;
            redirect_pend <= redirect_pend_nxt;
            cancel        <= cancel_nxt;
        end
    end

    // Next-state and redirect handling.
    always_comb begin
        state_nxt         = state;
        pc_nxt            = pc;
        redir_tgt_nxt     = redir_tgt;
        redirect_pend_nxt = redirect_pend;
        cancel_nxt        = cancel;
        load_buf          = 1'b0;

        case (state)
            S_REQ: begin
                // A redirect cannot retract an issued request; remember it
                // and turn the eventual response into a stale one.
                if (br_taken) begin
                    redir_tgt_nxt     = br_target;
                    redirect_pend_nxt = 1'b1;
                end
                if (inst_addr_ok) begin
                    state_nxt         = S_WAIT;
                    cancel_nxt        = redirect_pend || br_taken;
                    redirect_pend_nxt = 1'b0;
                end
            end

            S_WAIT: begin
                if (br_taken) begin
                    redir_tgt_nxt = br_target;
                    cancel_nxt    = 1'b1;
                end
                if (inst_data_ok) begin
                    if (cancel || br_taken) begin
                        // Stale response: drop it and restart at the newest target.
                        pc_nxt     = br_taken ? br_target : redir_tgt;
                        cancel_nxt = 1'b0;
                        state_nxt  = S_REQ;
                    end else begin
                        load_buf  = 1'b1;
                        state_nxt = S_HOLD;
                    end
                end
            end

            S_HOLD: begin
                if (br_taken) begin
                    pc_nxt    = br_target;
                    state_nxt = S_REQ;
                end else if (handshake) begin
                    pc_nxt    = pc + ADDR_W'(PC_STEP);
                    state_nxt = S_REQ;
                end
            end

            default: begin
                state_nxt = S_REQ;
            end
        endcase
    end

    // Instruction buffer toward ID; written only by an accepted response.
    always_ff @(posedge clk) begin
        if (reset) begin
            fs_pc   <= ADDR_W'(0);
            fs_inst <= INST_W'(0);
        end else if (load_buf) begin
            fs_pc   <= pc;
            fs_inst <= inst_rdata;
        end
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed cycle-by-cycle bench for if_fetch_ctrl: every vector lists the
// inputs held for one cycle and the outputs expected during that cycle.
module tb_if_fetch_ctrl;

    localparam logic [31:0] R    = 32'h1c000000;
    localparam logic [31:0] BAD  = 32'hdeadbeef;
    localparam logic [31:0] D0   = 32'h00000013;
    localparam logic [31:0] D1   = 32'h11110001;
    localparam logic [31:0] D2   = 32'h22220002;
    localparam logic [31:0] D3   = 32'h33330003;
    localparam logic [31:0] D4   = 32'h44440004;
    localparam logic [31:0] D5   = 32'h55550005;
    localparam logic [31:0] D6   = 32'h66660006;
    localparam logic [31:0] D7   = 32'h77770007;
    localparam logic [31:0] D8   = 32'h88880008;
    localparam logic [31:0] D9   = 32'h99990009;

    logic        clk;
    logic        reset;
    logic        br_taken;
    logic [31:0] br_target;
    logic        id_allowin;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        fs_to_ds_valid;
    logic [31:0] fs_pc;
    logic [31:0] fs_inst;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        rst;
        logic        aok;
        logic        dok;
        logic [31:0] rdata;
        logic        br;
        logic [31:0] tgt;
        logic        allow;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
    } vec_t;

    vec_t vecs[$];

    if_fetch_ctrl #(.RESET_PC(R)) dut (
        .clk            (clk),
        .reset          (reset),
        .br_taken       (br_taken),
        .br_target      (br_target),
        .id_allowin     (id_allowin),
        .inst_req       (inst_req),
        .inst_addr      (inst_addr),
        .inst_addr_ok   (inst_addr_ok),
        .inst_data_ok   (inst_data_ok),
        .inst_rdata     (inst_rdata),
        .fs_to_ds_valid (fs_to_ds_valid),
        .fs_pc          (fs_pc),
        .fs_inst        (fs_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, input logic aok, input logic dok,
                                input logic [31:0] rdata, input logic br,
                                input logic [31:0] tgt, input logic allow,
                                input logic e_req, input logic [31:0] e_addr,
                                input logic e_valid, input logic [31:0] e_pc,
                                input logic [31:0] e_inst);
        vec_t v;
        v.rst = rst; v.aok = aok; v.dok = dok; v.rdata = rdata;
        v.br = br; v.tgt = tgt; v.allow = allow;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
        v.e_pc = e_pc; v.e_inst = e_inst;
        return v;
    endfunction

    function automatic void add(input logic rst, input logic aok, input logic dok,
                                input logic [31:0] rdata, input logic br,
                                input logic [31:0] tgt, input logic allow,
                                input logic e_req, input logic [31:0] e_addr,
                                input logic e_valid, input logic [31:0] e_pc,
                                input logic [31:0] e_inst);
        vecs.push_back(mk(rst, aok, dok, rdata, br, tgt, allow,
                          e_req, e_addr, e_valid, e_pc, e_inst));
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    // Drive one cycle of inputs, compare outputs at mid-cycle, advance.
    task automatic apply(input vec_t v, input string tag);
        reset        = v.rst;
        inst_addr_ok = v.aok;
        inst_data_ok = v.dok;
        inst_rdata   = v.rdata;
        br_taken     = v.br;
        br_target    = v.tgt;
        id_allowin   = v.allow;
        @(negedge clk);
        check({tag, " inst_req"}, 32'(inst_req), 32'(v.e_req));
        if (v.e_req) check({tag, " inst_addr"}, inst_addr, v.e_addr);
        check({tag, " fs_to_ds_valid"}, 32'(fs_to_ds_valid), 32'(v.e_valid));
        check({tag, " fs_pc"}, fs_pc, v.e_pc);
        check({tag, " fs_inst"}, fs_inst, v.e_inst);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0;
        br_taken = 1'b0; br_target = 32'h0; id_allowin = 1'b1;
        @(posedge clk);
        #1;

        // Reset, then three back-to-back fetches with a 1-cycle SRAM.
        add(1,0,0,0,0,0,1, 0,R,0,0,0);
        add(1,0,0,0,0,0,1, 0,R,0,0,0);
        add(0,1,0,0,0,0,1, 1,R,0,0,0);
        add(0,0,1,D0,0,0,1, 0,0,0,0,0);
        add(0,0,0,0,0,0,1, 0,0,1,R,D0);
        add(0,1,0,0,0,0,1, 1,R+4,0,R,D0);
        add(0,0,1,D1,0,0,1, 0,0,0,R,D0);
        add(0,0,0,0,0,0,1, 0,0,1,R+4,D1);
        add(0,1,0,0,0,0,1, 1,R+8,0,R+4,D1);
        add(0,0,1,D2,0,0,1, 0,0,0,R+4,D1);
        add(0,0,0,0,0,0,1, 0,0,1,R+8,D2);
        // Reset, then addr_ok withheld for 4 cycles; address must hold.
        add(1,0,0,0,0,0,1, 0,0,0,R+8,D2);
        for (int i = 0; i < 4; i++) add(0,0,0,0,0,0,1, 1,R,0,0,0);
        add(0,1,0,0,0,0,1, 1,R,0,0,0);
        add(0,0,0,0,0,0,1, 0,0,0,0,0);
        add(0,0,0,0,0,0,1, 0,0,0,0,0);
        add(0,0,1,D3,0,0,1, 0,0,0,0,0);
        add(0,0,0,0,0,0,1, 0,0,1,R,D3);
        // Redirect while waiting: stale response is dropped.
        add(0,1,0,0,0,0,1, 1,R+4,0,R,D3);
        add(0,0,0,0,1,R+32'h100,1, 0,0,0,R,D3);
        add(0,0,1,BAD,0,0,1, 0,0,0,R,D3);
        add(0,1,0,0,0,0,1, 1,R+32'h100,0,R,D3);
        add(0,0,1,D4,0,0,1, 0,0,0,R,D3);
        // ID stalls for 5 cycles in HOLD.
        for (int i = 0; i < 5; i++) add(0,0,0,0,0,0,0, 0,0,1,R+32'h100,D4);
        add(0,0,0,0,0,0,1, 0,0,1,R+32'h100,D4);
        add(0,1,0,0,0,0,1, 1,R+32'h104,0,R+32'h100,D4);
        add(0,0,1,D5,0,0,1, 0,0,0,R+32'h100,D4);
        // Redirect in HOLD squashes the handoff.
        add(0,0,0,0,1,R+32'h400,1, 0,0,0,R+32'h104,D5);
        // Two redirects during a stalled REQ: newest target wins.
        add(0,0,0,0,1,R+32'h200,1, 1,R+32'h400,0,R+32'h104,D5);
        add(0,0,0,0,1,R+32'h300,1, 1,R+32'h400,0,R+32'h104,D5);
        add(0,0,0,0,0,0,1, 1,R+32'h400,0,R+32'h104,D5);
        add(0,1,0,0,0,0,1, 1,R+32'h400,0,R+32'h104,D5);
        add(0,0,1,BAD,0,0,1, 0,0,0,R+32'h104,D5);
        add(0,1,0,0,0,0,1, 1,R+32'h300,0,R+32'h104,D5);
        add(0,0,1,D6,0,0,1, 0,0,0,R+32'h104,D5);
        add(0,0,0,0,0,0,1, 0,0,1,R+32'h300,D6);
        // Reset mid-WAIT; a late data_ok in REQ is ignored.
        add(0,1,0,0,0,0,1, 1,R+32'h304,0,R+32'h300,D6);
        add(1,0,0,0,0,0,1, 0,0,0,R+32'h300,D6);
        add(0,0,1,BAD,0,0,1, 1,R,0,0,0);
        add(0,1,0,0,0,0,1, 1,R,0,0,0);
        add(0,0,1,D7,0,0,1, 0,0,0,0,0);
        add(0,0,0,0,0,0,1, 0,0,1,R,D7);
        // Redirect coincident with addr_ok, then with the stale data_ok.
        add(0,1,0,0,1,R+32'h500,1, 1,R+4,0,R,D7);
        add(0,0,1,BAD,0,0,1, 0,0,0,R,D7);
        add(0,1,0,0,0,0,1, 1,R+32'h500,0,R,D7);
        add(0,0,1,BAD,1,R+32'h600,1, 0,0,0,R,D7);
        add(0,1,0,0,0,0,1, 1,R+32'h600,0,R,D7);
        add(0,0,1,D8,0,0,1, 0,0,0,R,D7);
        add(0,0,0,0,0,0,1, 0,0,1,R+32'h600,D8);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // PC wraps modulo 2^32 after a fetch at the top word.
        apply(mk(0,1,0,0,1,32'hfffffffc,1, 1,R+32'h604,0,R+32'h600,D8), "wrap0");
        apply(mk(0,0,1,BAD,0,0,1, 0,0,0,R+32'h600,D8), "wrap1");
        apply(mk(0,1,0,0,0,0,1, 1,32'hfffffffc,0,R+32'h600,D8), "wrap2");
        apply(mk(0,0,1,D9,0,0,1, 0,0,0,R+32'h600,D8), "wrap3");
        apply(mk(0,0,0,0,0,0,1, 0,0,1,32'hfffffffc,D9), "wrap4");
        apply(mk(0,0,0,0,0,0,1, 1,32'h00000000,0,32'hfffffffc,D9), "wrap5");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
